// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way mux round-robin arbiter.
//   arb_state_t : FSM state (IDLE between owners, GRANT while one owns the mux)
//   sel_t       : 2-bit mux select / requester index
//   NREQ        : number of requesters sharing the mux
package mux_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [1:0] sel_t;
  localparam int NREQ = 4;
endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection, purely combinational.
//   req    : level requests, bit i = requester i
//   last   : most recent owner; scanning starts at last+1
//   winner : first set request at last+1, last+2, ... (mod 4)
//   any    : at least one request is set (winner is 0 when no request is set)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  sel_t            last,
  output sel_t            winner,
  output logic            any
);
  sel_t idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    any    = |req;
    // k = 4 wraps to last itself, so a lone request from the previous owner
    // still wins.
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req        : level requests (0=A, 1=B, 2=C, 3=D)
//   gnt        : registered one-hot grant (or zero)
//   S1, S0     : registered mux selects, written only on IDLE->GRANT
//   busy       : high while in GRANT
// An owner keeps the mux until it drops req, or until it has held MAX_HOLD
// cycles while someone else waits. Every owner change passes through one
// IDLE cycle with gnt = 0, so the selects never move under a live grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            S1,
  output logic            S0,
  output logic            busy
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t      state, state_n;
  sel_t            owner, owner_n, last, last_n, sel, sel_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [NREQ-1:0] gnt_n, others;
  sel_t            winner;
  logic            any, at_max;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  assign others = req & ~(NREQ'(1) << owner);
  assign at_max = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= 2'd3;
      sel      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      sel      <= sel_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    sel_n   = sel;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          owner_n = winner;
          sel_n   = winner;
          gnt_n   = NREQ'(1) << winner;
          hold_n  = '0;
        end
      end
      GRANT: begin
        // Release and preempt share one exit, so their overlap needs no
        // special case.
        if (!req[owner] || (at_max && |others)) begin
          state_n = IDLE;
          gnt_n   = '0;
          last_n  = owner;
        end else if (at_max) begin
          hold_n  = '0;
        end else begin
          hold_n  = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign {S1, S0} = sel;
  assign busy     = (state == GRANT);

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_sel_match: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt != '0) |-> gnt[{S1, S0}]);
  a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ($past(gnt) != '0) |-> $stable({S1, S0}));
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one `mux4to1` datapath among four requesters. It drives the mux selects `S1`/`S0` and a one-hot grant. Each owner keeps the mux until it releases or exceeds a bounded hold time. A mandatory one-cycle dead gap separates owners, and the selects never change while any grant is high.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when others are waiting. Legal range is 2..256.
- `clk`  in  1: the only clock. All logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: level request. `req[i]` asks for mux input i (0=A, 1=B, 2=C, 3=D).
- `gnt`  out  4: one-hot grant, or all zero. Registered.
- `S1`  out  1: mux select MSB. Registered.
- `S0`  out  1: mux select LSB. Registered.
- `busy`  out  1: high while in GRANT.

## Operation
- State machine with two states, IDLE and GRANT. There are internal registers `owner[1:0]`, `last[1:0]` and `hold_cnt`.
- Reset values:
  - State is IDLE.
  - `gnt` = 4'b0000, `{S1,S0}` = 2'b00, `busy` = 0.
  - `last` = 2'd3, so requester 0 has first priority.
  - `hold_cnt` = 0.
- IDLE:
  - If `req` is non-zero, the winner is the first set bit scanning `last+1`, `last+2`, … modulo 4.
  - At the next edge: `owner` = winner, `gnt` = 1<<winner, `{S1,S0}` = winner, `hold_cnt` = 0, go to GRANT.
  - If `req` is zero, stay in IDLE. `{S1,S0}` holds its previous value.
- GRANT, evaluated each cycle:
  - **Release:** `req[owner]` = 0. At the next edge `gnt` = 0, `last` = `owner`, go to IDLE.
  - **Preempt:** `req[owner]` = 1, `hold_cnt` = MAX_HOLD-1, and any other request is set. Same action as release.
  - **Renew:** `hold_cnt` = MAX_HOLD-1 and no other request is set. Stay in GRANT with `hold_cnt` = 0.
  - **Otherwise:** `hold_cnt` increments.
- Release and preempt at the same time: treated as release. The outcome is identical.
- Changes to non-owner `req` bits during GRANT do not affect `gnt` or the selects.
- `hold_cnt` width is `$clog2(MAX_HOLD)`. It never exceeds MAX_HOLD-1, so there is no wrap-around.
- `{S1,S0}` is written only on the IDLE→GRANT edge. It therefore equals the index of the set `gnt` bit whenever `gnt` ≠ 0.

## Timing
- Request-to-grant latency is 1 cycle from IDLE. `req` sampled high at edge N gives `gnt` high after edge N.
- Owner change: `gnt` is low for exactly 1 cycle between owners (the IDLE cycle). The new grant appears 2 edges after the release or preempt is sampled.
- Grant drops 1 edge after the owner deasserts `req`.
- Under continuous contention, each owner holds for exactly MAX_HOLD cycles.
- Worst-case wait from `req` to `gnt` with all four contending: 3·(MAX_HOLD+1)+1 cycles.
- Reset asserted mid-GRANT: `gnt` = 0, `busy` = 0 and `{S1,S0}` = 00 immediately, asynchronously. `last` returns to 3.

## Structure
- Package `mux_arb_pkg` contains:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
  - `typedef logic [1:0] sel_t`
  - `localparam int NREQ = 4`
- Sub-module `rr_pick`: purely combinational. Inputs are `req[3:0]` and `last[1:0]`. Outputs are `winner` (`sel_t`) and `any`. It is reused by the top and by the checker model.
- The existing `mux4to1` SVA checker binds alongside the arbiter, driven by `S1`/`S0`. Checker properties:
  - `$onehot0(gnt)`
  - `gnt != 0 |-> gnt[{S1,S0}]`
  - `$stable({S1,S0})` whenever `$past(gnt) != 0`

## Test plan
- **Reset then single request:** hold `req` = 4'b0100. `gnt` = 4'b0100 and `{S1,S0}` = 2'b10 one cycle after `req` is sampled. `busy` = 1.
- **All request, MAX_HOLD = 8:** grants run in order 0, 1, 2, 3, 0. Each grant lasts 8 cycles, with exactly one `gnt` = 0 cycle between grants.
- **Early release:**
  - Owner 1 drops `req` after 3 cycles while `req[3]` is pending.
  - `gnt` goes 0 for 1 cycle, then becomes 4'b1000 with `{S1,S0}` = 11.
  - `req[2]` is skipped because it is low.
- **Lone owner renewal:** only `req[0]` held for 20 cycles. `gnt` stays at 4'b0001 continuously, with no gap. `hold_cnt` restarts every 8 cycles.
- **Reset mid-GRANT:** pulse `rst_n` low while `gnt` = 4'b0010.
  - `gnt` = 0 and `{S1,S0}` = 00 without waiting for a clock edge.
  - After release, with `req` = 4'b1111, the first grant is 4'b0001.
- **Simultaneous release and hold expiry** at `hold_cnt` = 7: single transition to IDLE, 1-cycle gap, then the next requester in round-robin order is granted.
